// File: rtl/helicopter_pkg.sv
// -----------------------------------------------------------------------------
// helicopter_pkg
// Shared constants and helpers for the helicopter game cave path.
//   - screen geometry (640x480), column width and visible column count
//   - cave ring-buffer depth, gap height, step and wall margin
//   - player column / height
//   - LFSR seed and tap mask, LFSR next-state helper
//   - gap move encoding and the clamped new-gap helper
// -----------------------------------------------------------------------------
package helicopter_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int COL_W      = 16;
    localparam int NUM_COLS   = 40;
    localparam int BUF_DEPTH  = 64;
    localparam int GAP_H      = 160;
    localparam int STEP       = 16;
    localparam int MARGIN     = 16;
    localparam int PLAYER_COL = 8;
    localparam int PLAYER_H   = 8;

    // Sized forms of the geometry used directly in RTL arithmetic
    localparam logic [8:0]  GAP_INIT     = 9'd160;
    localparam logic [8:0]  GAP_MIN      = 9'd16;    // MARGIN
    localparam logic [8:0]  GAP_MAX      = 9'd304;   // SCREEN_H - MARGIN - GAP_H
    localparam logic [8:0]  GAP_STEP     = 9'd16;
    localparam logic [9:0]  GAP_H_10     = 10'd160;
    localparam logic [10:0] GAP_H_11     = 11'd160;
    localparam logic [10:0] PLAYER_H_11  = 11'd8;
    localparam logic [5:0]  PLAYER_OFS   = 6'd8;     // PLAYER_COL
    localparam logic [5:0]  LAST_COL_OFS = 6'd39;    // NUM_COLS - 1
    localparam logic [5:0]  NEW_COL_OFS  = 6'd40;    // NUM_COLS
    localparam logic [5:0]  NUM_COLS_6   = 6'd40;

    // Fibonacci LFSR, taps 16,14,13,11 in shift-right form: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Meaning of lfsr[1:0] when a new column is generated
    typedef enum logic [1:0] {
        MOVE_RAISE  = 2'b00,   // gap_top - STEP
        MOVE_HOLD_A = 2'b01,
        MOVE_HOLD_B = 2'b10,
        MOVE_LOWER  = 2'b11    // gap_top + STEP
    } gap_move_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {^(state & LFSR_TAPS), state[15:1]};
    endfunction

    // New gap_top from the previous column, clamped to [GAP_MIN, GAP_MAX]
    function automatic logic [8:0] next_gap(input logic [8:0] prev, input logic [1:0] sel);
        logic [8:0] gap;
        case (gap_move_e'(sel))
            MOVE_RAISE:  gap = (prev < (GAP_MIN + GAP_STEP)) ? GAP_MIN : (prev - GAP_STEP);
            MOVE_LOWER:  gap = (prev > (GAP_MAX - GAP_STEP)) ? GAP_MAX : (prev + GAP_STEP);
            MOVE_HOLD_A: gap = prev;
            MOVE_HOLD_B: gap = prev;
            default:     gap = prev;
        endcase
        return gap;
    endfunction

endpackage

// File: rtl/cave_lfsr16.sv
// -----------------------------------------------------------------------------
// cave_lfsr16
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11). Loads SEED on reset and
// advances once per clock while enable is high. Deliberately has no game-level
// clear so the cave keeps varying between games.
// Ports:
//   ClkPort  in   system clock
//   reset    in   async, active-high
//   enable   in   advance the register this cycle
//   lfsr     out  current LFSR state (registered)
// -----------------------------------------------------------------------------
module cave_lfsr16
    import helicopter_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        ClkPort,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_r;

    // LFSR state register
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            lfsr_r <= SEED;
        end else if (enable) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign lfsr = lfsr_r;

endmodule

// File: rtl/cave_wall_engine.sv
// -----------------------------------------------------------------------------
// cave_wall_engine
// Generates the scrolling cave for the helicopter game (per-column gap_top in a
// 64-entry ring, 40 columns visible), detects player/wall collision, keeps score
// and high score, and answers per-pixel wall queries for the VGA colour path.
// Ports:
//   ClkPort     in   system clock
//   reset       in   async, active-high
//   game_run    in   game in PLAY: scrolling, scoring and collision enabled
//   game_clear  in   game in INIT: clears cave, head, divider, score, collision
//   player_y    in   player top row, px
//   CounterX    in   VGA pixel x
//   CounterY    in   VGA pixel y
//   wall_pixel  out  (CounterX,CounterY) is wall, one clock after the query
//   collision   out  sticky collision flag
//   hsFlag      out  score > high_score (registered)
//   score       out  current score, saturating at 1023
//   high_score  out  best score since reset
// Configuration:
//   SCROLL_SPEEDUP_EN  when defined, the scroll divider shrinks by SCROLL_DIV/20
//                      every 32 ticks (floor SCROLL_DIV/4); otherwise it is fixed.
// -----------------------------------------------------------------------------
module cave_wall_engine
    import helicopter_pkg::*;
#(
    parameter int unsigned SCROLL_DIV = 12_500_000
) (
    input  logic       ClkPort,
    input  logic       reset,
    input  logic       game_run,
    input  logic       game_clear,
    input  logic [9:0] player_y,
    input  logic [9:0] CounterX,
    input  logic [9:0] CounterY,
    output logic       wall_pixel,
    output logic       collision,
    output logic       hsFlag,
    output logic [9:0] score,
    output logic [9:0] high_score
);

    localparam logic [23:0] DIV_FULL = 24'(SCROLL_DIV);

    logic [8:0]  gap_r [0:BUF_DEPTH-1];
    logic [5:0]  head_r;
    logic [23:0] div_r;
    logic [9:0]  score_r;
    logic [9:0]  high_score_r;
    logic        collision_r;
    logic        hs_flag_r;
    logic        wall_pixel_r;

    logic [15:0] lfsr_s;
    logic [23:0] divider_s;
    logic [5:0]  pix_col_s;
    logic [8:0]  player_gap_s;
    logic [8:0]  pix_gap_s;
    logic [8:0]  new_gap_s;
    logic        run_en_s;
    logic        tick_s;
    logic        hit_s;
    logic        set_coll_s;
    logic        wall_s;

    cave_lfsr16 #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .ClkPort (ClkPort),
        .reset   (reset),
        .enable  (1'b1),
        .lfsr    (lfsr_s)
    );

`ifdef SCROLL_SPEEDUP_EN
    localparam logic [23:0] DIV_DEC   = 24'(SCROLL_DIV / 20);
    localparam logic [23:0] DIV_FLOOR = 24'(SCROLL_DIV / 4);

    logic [23:0] divider_r;
    logic [4:0]  tick_cnt_r;

    // Scroll speed-up: shorten the divider every 32 ticks down to a floor
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            divider_r  <= DIV_FULL;
            tick_cnt_r <= 5'd0;
        end else if (game_clear) begin
            divider_r  <= DIV_FULL;
            tick_cnt_r <= 5'd0;
        end else if (tick_s) begin
            tick_cnt_r <= tick_cnt_r + 5'd1;
            if (tick_cnt_r == 5'd31) begin
                divider_r <= (divider_r >= (DIV_FLOOR + DIV_DEC)) ? (divider_r - DIV_DEC) : DIV_FLOOR;
            end
        end
    end

    assign divider_s = divider_r;
`else
    assign divider_s = DIV_FULL;
`endif

    // Ring lookups: visible column c lives at entry head+c (6-bit wrap)
    assign pix_col_s    = CounterX[9:4];
    assign player_gap_s = gap_r[head_r + PLAYER_OFS];
    assign pix_gap_s    = gap_r[head_r + pix_col_s];
    assign new_gap_s    = next_gap(gap_r[head_r + LAST_COL_OFS], lfsr_s[1:0]);

    // Tick, collision and pixel decode from the current state
    always_comb begin
        run_en_s   = 1'b0;
        tick_s     = 1'b0;
        hit_s      = 1'b0;
        set_coll_s = 1'b0;
        wall_s     = 1'b0;

        run_en_s = game_run && !collision_r;
        // >= keeps the divider safe if it is shortened below the current count
        if (run_en_s && (div_r >= (divider_s - 24'd1))) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end

        if (({1'b0, player_y} < {2'b00, player_gap_s}) ||
            (({1'b0, player_y} + PLAYER_H_11) > ({2'b00, player_gap_s} + GAP_H_11))) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        set_coll_s = game_run && hit_s && !game_clear;

        if (pix_col_s < NUM_COLS_6) begin
            wall_s = (CounterY < {1'b0, pix_gap_s}) || (CounterY >= ({1'b0, pix_gap_s} + GAP_H_10));
        end else begin
            wall_s = 1'b0;
        end
    end

    // Cave ring buffer: flat cave on reset/clear, one new column per tick
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                gap_r[i] <= GAP_INIT;
            end
        end else if (game_clear) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                gap_r[i] <= GAP_INIT;
            end
        end else if (tick_s) begin
            gap_r[head_r + NEW_COL_OFS] <= new_gap_s;
        end
    end

    // Scroll divider, head pointer, score and sticky collision
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            head_r      <= 6'd0;
            div_r       <= 24'd0;
            score_r     <= 10'd0;
            collision_r <= 1'b0;
        end else if (game_clear) begin
            head_r      <= 6'd0;
            div_r       <= 24'd0;
            score_r     <= 10'd0;
            collision_r <= 1'b0;
        end else begin
            if (tick_s) begin
                div_r   <= 24'd0;
                head_r  <= head_r + 6'd1;
                score_r <= (score_r == 10'd1023) ? score_r : (score_r + 10'd1);
            end else if (run_en_s) begin
                div_r <= div_r + 24'd1;
            end
            if (set_coll_s) begin
                collision_r <= 1'b1;
            end
        end
    end

    // High score capture on the rising collision when the run beat the record
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            high_score_r <= 10'd0;
        end else if (set_coll_s && !collision_r && hs_flag_r) begin
            high_score_r <= score_r;
        end
    end

    // Registered record flag and pixel answer
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            hs_flag_r    <= 1'b0;
            wall_pixel_r <= 1'b0;
        end else begin
            hs_flag_r    <= (score_r > high_score_r);
            wall_pixel_r <= wall_s;
        end
    end

    // Sub-column pixel bits and the upper LFSR bits are intentionally not used
    logic unused_s;
    assign unused_s = ^{CounterX[3:0], lfsr_s[15:2]};

    assign wall_pixel = wall_pixel_r;
    assign collision  = collision_r;
    assign hsFlag     = hs_flag_r;
    assign score      = score_r;
    assign high_score = high_score_r;

endmodule

// File: tb/tb_cave_wall_engine.sv
// -----------------------------------------------------------------------------
// tb_cave_wall_engine
// Randomized bench for cave_wall_engine with SCROLL_DIV=8. The reference model
// keeps the visible cave as a queue of 40 gap_top values (leftmost first), a
// plain scroll counter, score, high score and the game LFSR, and is stepped on
// every rising clock edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cave_wall_engine;

    localparam int SD = 8;

    logic       ClkPort = 1'b0;
    logic       reset;
    logic       game_run;
    logic       game_clear;
    logic [9:0] player_y;
    logic [9:0] CounterX;
    logic [9:0] CounterY;
    logic       wall_pixel;
    logic       collision;
    logic       hsFlag;
    logic [9:0] score;
    logic [9:0] high_score;

    cave_wall_engine #(.SCROLL_DIV(SD)) dut (
        .ClkPort    (ClkPort),
        .reset      (reset),
        .game_run   (game_run),
        .game_clear (game_clear),
        .player_y   (player_y),
        .CounterX   (CounterX),
        .CounterY   (CounterY),
        .wall_pixel (wall_pixel),
        .collision  (collision),
        .hsFlag     (hsFlag),
        .score      (score),
        .high_score (high_score)
    );

    always #5 ClkPort = ~ClkPort;

    int check_cnt = 0;
    int err_cnt   = 0;

    // Reference model state
    int          cave[$];
    int          m_div;
    int          m_score;
    int          m_high;
    bit          m_coll;
    bit          m_hs;
    bit          m_wall;
    logic [15:0] m_lfsr;

    task automatic check_val(input string tag, input int actual, input int expected);
        check_cnt++;
        if (actual != expected) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        cave.delete();
        for (int i = 0; i < 40; i++) cave.push_back(160);
        m_div   = 0;
        m_score = 0;
        m_high  = 0;
        m_coll  = 1'b0;
        m_hs    = 1'b0;
        m_wall  = 1'b0;
        m_lfsr  = 16'hACE1;
    endtask

    // One rising edge of the game, from the rules: everything uses pre-edge values
    task automatic model_clock();
        int          g_player;
        int          old_score;
        int          old_high;
        bit          old_coll;
        bit          old_hs;
        logic [15:0] old_lfsr;
        int          col;
        int          prev;
        int          ng;
        bit          hit;
        g_player  = cave[8];
        old_score = m_score;
        old_high  = m_high;
        old_coll  = m_coll;
        old_hs    = m_hs;
        old_lfsr  = m_lfsr;

        col = int'(CounterX) / 16;
        if (col < 40) m_wall = (int'(CounterY) < cave[col]) || (int'(CounterY) >= cave[col] + 160);
        else          m_wall = 1'b0;
        m_hs = (old_score > old_high);

        if (game_clear) begin
            foreach (cave[i]) cave[i] = 160;
            m_div   = 0;
            m_score = 0;
            m_coll  = 1'b0;
        end else begin
            hit = game_run && ((int'(player_y) < g_player) || (int'(player_y) + 8 > g_player + 160));
            if (game_run && !old_coll) begin
                if (m_div == SD - 1) begin
                    m_div = 0;
                    prev  = cave[39];
                    case (old_lfsr[1:0])
                        2'b00:   ng = prev - 16;
                        2'b11:   ng = prev + 16;
                        default: ng = prev;
                    endcase
                    if (ng < 16)  ng = 16;
                    if (ng > 304) ng = 304;
                    void'(cave.pop_front());
                    cave.push_back(ng);
                    if (m_score < 1023) m_score++;
                end else begin
                    m_div++;
                end
            end
            if (hit) begin
                m_coll = 1'b1;
                if (!old_coll && old_hs) m_high = old_score;
            end
        end
        m_lfsr = {old_lfsr[0] ^ old_lfsr[2] ^ old_lfsr[3] ^ old_lfsr[5], old_lfsr[15:1]};
    endtask

    task automatic check_outputs();
        check_val("wall_pixel", int'(wall_pixel), int'(m_wall));
        check_val("collision",  int'(collision),  int'(m_coll));
        check_val("hsFlag",     int'(hsFlag),     int'(m_hs));
        check_val("score",      int'(score),      m_score);
        check_val("high_score", int'(high_score), m_high);
    endtask

    task automatic cycle();
        @(posedge ClkPort);
        model_clock();
        @(negedge ClkPort);
        check_outputs();
    endtask

    // Random pixel query, often placed right on a gap edge
    task automatic drive_pixel();
        int col;
        int sel;
        CounterX = 10'($urandom_range(0, 1023));
        col = int'(CounterX) / 16;
        sel = $urandom_range(0, 7);
        if (col < 40 && sel < 4) begin
            case (sel)
                0:       CounterY = 10'(cave[col] - 1);
                1:       CounterY = 10'(cave[col]);
                2:       CounterY = 10'(cave[col] + 159);
                default: CounterY = 10'(cave[col] + 160);
            endcase
        end else begin
            CounterY = 10'($urandom_range(0, 1023));
        end
    endtask

    // Player inside the gap at the player column, including both edge rows
    task automatic drive_safe_player();
        int g;
        int sel;
        g = cave[8];
        sel = $urandom_range(0, 9);
        if (sel == 0)      player_y = 10'(g);
        else if (sel == 1) player_y = 10'(g + 152);
        else               player_y = 10'(g + $urandom_range(0, 152));
    endtask

    int hi_saved;
    int score_saved;

    initial begin
        reset      = 1'b1;
        game_run   = 1'b0;
        game_clear = 1'b0;
        player_y   = 10'd200;
        CounterX   = 10'd0;
        CounterY   = 10'd0;
        model_reset();
        repeat (3) @(negedge ClkPort);

        // Reset state
        check_val("rst_wall",  int'(wall_pixel), 0);
        check_val("rst_coll",  int'(collision),  0);
        check_val("rst_hs",    int'(hsFlag),     0);
        check_val("rst_score", int'(score),      0);
        check_val("rst_high",  int'(high_score), 0);
        reset = 1'b0;

        // Pixel queries on the flat cave: 1-cycle latency
        CounterX = 10'd0;   CounterY = 10'd10;  cycle();
        check_val("px_top_wall", int'(wall_pixel), 1);
        CounterY = 10'd200; cycle();
        check_val("px_in_gap", int'(wall_pixel), 0);
        CounterX = 10'd640; CounterY = 10'd10;  cycle();
        check_val("px_off_screen", int'(wall_pixel), 0);

        // Steady play in the middle of the flat cave: score 1,2,3...
        game_run = 1'b1;
        player_y = 10'd200;
        for (int k = 1; k <= 4; k++) begin
            repeat (SD) begin
                drive_pixel();
                cycle();
            end
            check_val("score_step", int'(score), k);
            check_val("no_coll", int'(collision), 0);
        end

        // Player above the gap: collision next cycle, record captured, freeze
        player_y = 10'd100;
        cycle();
        check_val("coll_set", int'(collision), 1);
        cycle();
        check_val("hs_capture", int'(high_score), 4);
        score_saved = m_score;
        repeat (20) begin
            drive_pixel();
            cycle();
        end
        check_val("score_frozen", int'(score), score_saved);

        // Clear, then a short game that does not beat the record
        hi_saved   = m_high;
        game_clear = 1'b1;
        cycle();
        game_clear = 1'b0;
        check_val("clr_score", int'(score), 0);
        check_val("clr_coll",  int'(collision), 0);
        player_y = 10'd200;
        repeat (2 * SD) cycle();
        player_y = 10'd100;
        repeat (3) cycle();
        check_val("hs_kept", int'(high_score), hi_saved);
        check_val("hs_flag_low", int'(hsFlag), 0);

        // Clear in the same cycle as a tick
        game_clear = 1'b1;
        cycle();
        game_clear = 1'b0;
        for (int n = 0; n < 40 && m_div != SD - 1; n++) begin
            drive_safe_player();
            cycle();
        end
        game_clear = 1'b1;
        cycle();
        game_clear = 1'b0;
        check_val("clr_tick_score", int'(score), 0);

        // Long run: head wraps many times, gap hits both clamps, score saturates
        for (int n = 0; n < 1100 * SD; n++) begin
            drive_safe_player();
            drive_pixel();
            cycle();
        end
        check_val("score_sat", int'(score), 1023);
        player_y = 10'(cave[8] - 1);
        repeat (2) cycle();
        check_val("hs_sat", int'(high_score), 1023);

        // Random games with clears and occasional unsafe player positions
        for (int n = 0; n < 3000; n++) begin
            game_clear = ($urandom_range(0, 59) == 0);
            game_run   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) player_y = 10'($urandom_range(0, 479));
            else drive_safe_player();
            drive_pixel();
            cycle();
        end

        // Async reset in the middle of a scroll interval
        game_clear = 1'b1;
        cycle();
        game_clear = 1'b0;
        game_run   = 1'b1;
        for (int n = 0; n < 40 && m_div != 3; n++) begin
            drive_safe_player();
            cycle();
        end
        @(posedge ClkPort);
        model_clock();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_val("arst_wall",  int'(wall_pixel), 0);
        check_val("arst_coll",  int'(collision),  0);
        check_val("arst_hs",    int'(hsFlag),     0);
        check_val("arst_score", int'(score),      0);
        check_val("arst_high",  int'(high_score), 0);
        repeat (2) @(negedge ClkPort);
        reset = 1'b0;
        for (int n = 0; n < 400; n++) begin
            drive_safe_player();
            drive_pixel();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
